// File: rtl/parser_pkg.sv
// Shared types and constants for the market-data message parser and its
// downstream consumers.
package parser_pkg;

    typedef enum logic [7:0] {
        MSG_NULL   = 8'h00,
        MSG_ADD    = 8'h41,
        MSG_DELETE = 8'h44,
        MSG_EXEC   = 8'h45
    } msg_type_t;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic [7:0]  stock_id;
        logic [31:0] order_id;
        logic [31:0] price;
        logic [31:0] quantity;
        logic [15:0] padding;
    } parsed_msg_t;

    typedef enum logic [2:0] {
        ST_TYPE,
        ST_STOCK,
        ST_ORDER,
        ST_PRICE,
        ST_QTY,
        ST_PAD
    } parser_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TYPE    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    localparam int TYPE_LEN  = 1;
    localparam int STOCK_LEN = 1;
    localparam int ORDER_LEN = 4;
    localparam int PRICE_LEN = 4;
    localparam int QTY_LEN   = 4;
    localparam int PAD_LEN   = 2;

    localparam int ADD_LEN  = TYPE_LEN + STOCK_LEN + ORDER_LEN + PRICE_LEN + QTY_LEN + PAD_LEN;
    localparam int DEL_LEN  = TYPE_LEN + STOCK_LEN + ORDER_LEN;
    localparam int EXEC_LEN = TYPE_LEN + STOCK_LEN + ORDER_LEN + QTY_LEN;

    // Folds one byte into a 32-bit field: shift-in for big-endian, lane write otherwise.
    function automatic logic [31:0] put_byte(input logic [31:0] field, input logic [1:0] idx,
                                             input logic [7:0] b, input logic msb_first);
        logic [31:0] r;
        r = field;
        if (msb_first) begin
            r = {field[23:0], b};
        end else begin
            r[{idx, 3'b000} +: 8] = b;
        end
        return r;
    endfunction

    function automatic logic is_known_type(input logic [7:0] b);
        return (b == MSG_ADD) || (b == MSG_DELETE) || (b == MSG_EXEC);
    endfunction

endpackage

// File: rtl/msg_out_reg.sv
// One-entry valid/ready holding register for parsed messages; a new load may
// replace the held entry in the same cycle the consumer takes it.
module msg_out_reg
    import parser_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  parsed_msg_t load_msg,
    input  logic        out_ready,
    output logic        slot_free,
    output logic        out_valid,
    output parsed_msg_t out_msg
);

    logic        valid_reg;
    parsed_msg_t msg_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            msg_reg   <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            msg_reg   <= load_msg;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign slot_free = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_msg   = msg_reg;

endmodule

// File: rtl/msg_stream_parser.sv
// Byte-stream ADD/DELETE/EXECUTE parser: assembles variable-length messages into
// parsed_msg_t, flags unknown types and mid-message timeouts, keeps statistics.
module msg_stream_parser
    import parser_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output parsed_msg_t      out_msg,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] LAST_WORD = 2'(ORDER_LEN - 1);
    localparam logic [1:0] LAST_PAD  = 2'(PAD_LEN - 1);

    parser_state_t     state_reg, state_next;
    logic [1:0]        idx_reg, idx_next;
    logic [7:0]        type_reg, type_next;
    logic [7:0]        stock_reg, stock_next;
    logic [31:0]       order_reg, order_next;
    logic [31:0]       price_reg, price_next;
    logic [31:0]       qty_reg, qty_next;
    logic [15:0]       pad_reg, pad_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    logic              err_valid_reg;
    err_code_t         err_code_reg;
    logic [CNT_W-1:0]  msg_count_reg, err_count_reg;

    logic        accept, is_last, slot_free, load, type_err, timeout_hit;
    parsed_msg_t done_msg;

    always_comb begin
        is_last = 1'b0;
        case (state_reg)
            ST_ORDER: is_last = (idx_reg == LAST_WORD) && (type_reg == MSG_DELETE);
            ST_QTY:   is_last = (idx_reg == LAST_WORD) && (type_reg == MSG_EXEC);
            ST_PAD:   is_last = (idx_reg == LAST_PAD);
            default:  is_last = 1'b0;
        endcase
    end

    // Only the final byte of a message can be held off by a full output slot.
    assign in_ready = !is_last || slot_free;
    assign accept   = in_valid && in_ready;
    assign load     = accept && is_last;
    assign type_err = accept && (state_reg == ST_TYPE) && !is_known_type(in_data);

    // A stalled final byte keeps in_valid high, so it never counts as idle.
    assign timeout_hit = (TIMEOUT != 0) && (state_reg != ST_TYPE) && !in_valid
                         && (idle_reg == IDLE_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        type_next  = type_reg;
        stock_next = stock_reg;
        order_next = order_reg;
        price_next = price_reg;
        qty_next   = qty_reg;
        pad_next   = pad_reg;
        idle_next  = idle_reg;

        if (accept || state_reg == ST_TYPE) begin
            idle_next = '0;
        end else if (!in_valid) begin
            idle_next = idle_reg + 1'b1;
        end

        if (accept) begin
            case (state_reg)
                ST_TYPE: begin
                    if (is_known_type(in_data)) begin
                        type_next  = in_data;
                        stock_next = '0;
                        order_next = '0;
                        price_next = '0;
                        qty_next   = '0;
                        pad_next   = '0;
                        idx_next   = '0;
                        state_next = ST_STOCK;
                    end
                end
                ST_STOCK: begin
                    stock_next = in_data;
                    idx_next   = '0;
                    state_next = ST_ORDER;
                end
                ST_ORDER: begin
                    order_next = put_byte(order_reg, idx_reg, in_data, MSB_FIRST);
                    idx_next   = idx_reg + 2'd1;
                    if (idx_reg == LAST_WORD) begin
                        idx_next = '0;
                        if (type_reg == MSG_DELETE)    state_next = ST_TYPE;
                        else if (type_reg == MSG_EXEC) state_next = ST_QTY;
                        else                           state_next = ST_PRICE;
                    end
                end
                ST_PRICE: begin
                    price_next = put_byte(price_reg, idx_reg, in_data, MSB_FIRST);
                    idx_next   = idx_reg + 2'd1;
                    if (idx_reg == LAST_WORD) begin
                        idx_next   = '0;
                        state_next = ST_QTY;
                    end
                end
                ST_QTY: begin
                    qty_next = put_byte(qty_reg, idx_reg, in_data, MSB_FIRST);
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == LAST_WORD) begin
                        idx_next   = '0;
                        state_next = (type_reg == MSG_EXEC) ? ST_TYPE : ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (MSB_FIRST) pad_next = {pad_reg[7:0], in_data};
                    else           pad_next[{idx_reg[0], 3'b000} +: 8] = in_data;
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == LAST_PAD) begin
                        idx_next   = '0;
                        state_next = ST_TYPE;
                    end
                end
                default: state_next = ST_TYPE;
            endcase
        end else if (timeout_hit) begin
            idx_next   = '0;
            state_next = ST_TYPE;
        end
    end

    // The final byte is folded in combinationally so the message loads on acceptance.
    assign done_msg = '{msg_type: type_next, stock_id: stock_next, order_id: order_next,
                        price: price_next, quantity: qty_next, padding: pad_next};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_TYPE;
            idx_reg       <= '0;
            type_reg      <= '0;
            stock_reg     <= '0;
            order_reg     <= '0;
            price_reg     <= '0;
            qty_reg       <= '0;
            pad_reg       <= '0;
            idle_reg      <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
            msg_count_reg <= '0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            type_reg      <= type_next;
            stock_reg     <= stock_next;
            order_reg     <= order_next;
            price_reg     <= price_next;
            qty_reg       <= qty_next;
            pad_reg       <= pad_next;
            idle_reg      <= idle_next;
            err_valid_reg <= type_err || timeout_hit;
            err_code_reg  <= type_err ? ERR_TYPE : (timeout_hit ? ERR_TIMEOUT : ERR_NONE);
            if (load && msg_count_reg != '1) begin
                msg_count_reg <= msg_count_reg + CNT_W'(1);
            end
            if ((type_err || timeout_hit) && err_count_reg != '1) begin
                err_count_reg <= err_count_reg + CNT_W'(1);
            end
        end
    end

    msg_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_msg  (done_msg),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_valid (out_valid),
        .out_msg   (out_msg)
    );

    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;
    assign msg_count = msg_count_reg;
    assign err_count = err_count_reg;

endmodule

// File: doc/msg_stream_parser.md
# msg_stream_parser

Parametrised byte-stream market-data parser, successor to the fixed 16-byte parser. It accepts a valid/ready byte stream carrying variable-length ADD/DELETE/EXECUTE messages and assembles each into a `parsed_msg_t`. The result is presented on a one-entry valid/ready output register, with error detection for unknown types and inter-byte timeout, plus message and error statistics. It sits between the byte-deframer and the order-book update logic.

## Interface
- `MSB_FIRST`, 1: multi-byte fields shift in most-significant byte first; 0 = little-endian (first byte lands in [7:0]).
- `TIMEOUT`, 64: idle cycles allowed mid-message before abort; 0 disables the timeout.
- `CNT_W`, 16: width of the statistics counters.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  byte present.
- `in_data`  in  8  byte.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `out_valid`  out  1  parsed message held.
- `out_ready`  in  1  consumer takes message.
- `out_msg`  out  `$bits(parsed_msg_t)`  parsed message.
- `err_valid`  out  1  one-cycle error pulse.
- `err_code`  out  2  `ERR_NONE`=0, `ERR_TYPE`=1, `ERR_TIMEOUT`=2; valid with `err_valid`.
- `msg_count`  out  `CNT_W`  messages delivered to the output register, saturating.
- `err_count`  out  `CNT_W`  errors, saturating.

## Operation
- **Field states:** TYPE → STOCK → ORDER(4) → PRICE(4) → QTY(4) → PAD(2), selected per type. A field byte counter resets at each field start.
- **Per-type sequences:**
  - `MSG_ADD` (0x41, 16 B): all fields.
  - `MSG_DELETE` (0x44, 6 B): TYPE, STOCK, ORDER only.
  - `MSG_EXEC` (0x45, 10 B): TYPE, STOCK, ORDER, QTY.
- **Absent fields** are output as 0.
- **Unknown type byte:** byte consumed, `err_valid`=1 with `ERR_TYPE`, FSM stays in TYPE. No resync beyond this; the next byte is treated as a type.
- **Field assembly:**
  - `MSB_FIRST`=1: `field <= {field[W-9:0], byte}`.
  - `MSB_FIRST`=0: byte k written to bits [8k+7:8k].
  - Field registers clear at TYPE acceptance.
- **Completion:** accepting the final byte of a message loads `out_msg` and sets `out_valid`, increments `msg_count`, and returns the FSM to TYPE.
- **Back-pressure:**
  - Bytes other than a message's final byte are always accepted.
  - The final byte is stalled (`in_ready`=0) while `out_valid && !out_ready`.
  - If `out_ready`=1 in the same cycle, the register reloads; pass-through is allowed.
- **Timeout:**
  - The idle counter clears on every accepted byte and counts while the FSM is not in TYPE.
  - On reaching `TIMEOUT`, the partial message is discarded, the FSM returns to TYPE, and `err_valid`=1 with `ERR_TIMEOUT`.
  - A stalled final byte (`in_valid`=1, `in_ready`=0) does not count as idle.
- **Simultaneous events:** a byte accepted in the timeout cycle wins; no error is raised. `err_count` and `msg_count` never increment in the same cycle.
- **Reset values:** every output is 0 except `in_ready`=1. FSM = TYPE; partial messages and the held output are lost.

## Timing
- `out_valid` rises the cycle after the final byte is accepted; latency is 1 cycle.
- `out_msg` is stable while `out_valid && !out_ready`.
- `err_valid` is asserted the cycle after the offending byte or timeout expiry, for exactly 1 cycle.
- Throughput is 1 byte/clk with no bubbles between messages, e.g. a 16 B ADD in 16 consecutive cycles.
- `in_ready` is combinational from `out_valid`, `out_ready` and state; there is no path from `in_valid`.
- Counters update in the same cycle as `out_valid`/`err_valid` rises.

## Structure
- **Package `parser_pkg`:**
  - `msg_type_t` enum (`MSG_NULL`=0x00, `MSG_ADD`=0x41, `MSG_DELETE`=0x44, `MSG_EXEC`=0x45).
  - `parsed_msg_t` struct: msg_type 8, stock_id 8, order_id 32, price 32, quantity 32, padding 16.
  - `parser_state_t`, `err_code_t`.
  - Field length constants and `ADD_LEN`/`DEL_LEN`/`EXEC_LEN`.
- **Sub-module `msg_out_reg`:** a one-entry valid/ready holding register for `parsed_msg_t`, reused downstream.

## Test plan
- **ADD, big-endian:** ADD bytes 41 07 00 00 12 34 00 00 27 10 00 00 00 64 00 00 with `MSB_FIRST`=1, `out_ready`=1 → `out_valid` 1 cycle after the 16th byte. Expect order_id=0x1234, price=0x2710, quantity=0x64, msg_count=1.
- **DELETE then EXEC, little-endian:** back-to-back DELETE (44 03 78 56 34 12) then EXEC (45 03 78 56 34 12 05 00 00 00) with `MSB_FIRST`=0 → two messages:
  - DELETE: order_id=0x12345678, price=qty=0.
  - EXEC: order_id=0x12345678, qty=5.
  - No idle cycles between them.
- **Back-pressure:** `out_ready`=0 while a second ADD streams in → 15 bytes accepted, `in_ready`=0 on the 16th. First message unchanged until `out_ready`=1; second loads the same cycle.
- **Unknown type:** byte 0x5A followed by a valid DELETE → `err_valid` with `ERR_TYPE`, err_count=1, then DELETE parsed correctly.
- **Timeout:** `TIMEOUT`=8, stop after 5 bytes of an ADD → `ERR_TIMEOUT` 8 idle cycles later, next 0x44… parses as DELETE. Repeat with a byte arriving exactly at the expiry cycle → no error.
- **Reset mid-operation:** reset asserted mid-message and while `out_valid`=1 → all outputs 0 and `in_ready`=1 immediately. The next full message parses normally.
